// File: rtl/demux_1x2_8bits.sv
// rtl/demux_1x2_8bits.sv - two-lane transmit byte striper with orphan-byte pad flush
//
// Purpose: splits one byte stream across two lanes. Even stream positions go
// to lane 0 and odd positions to lane 1. Both lanes of a pair are emitted on
// the same cycle. A lone lane-0 byte is flushed against PAD_BYTE after
// IDLE_LIMIT empty cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   data_in    in   byte to stripe
//   valid_in   in   data_in valid; always accepted
//   data_out0  out  lane 0 byte (registered, holds while invalid)
//   data_out1  out  lane 1 byte or PAD_BYTE (registered, holds while invalid)
//   valid0     out  lane 0 valid
//   valid1     out  lane 1 valid, identical to valid0
//   pad_out    out  lane 1 carries PAD_BYTE this pair
//   pair_count out  pairs emitted since reset, padded pairs included; wraps
module demux_1x2_8bits #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = 8'hF7,
    parameter int                    IDLE_LIMIT = 4,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic                  valid0,
    output logic                  valid1,
    output logic                  pad_out,
    output logic [CNT_WIDTH-1:0]  pair_count
);

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_LIMIT - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [7:0]            r_idle_cnt;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  r_valid;
    logic                  r_pad;
    logic [CNT_WIDTH-1:0]  r_pair_count;
    logic                  w_emit;
    logic                  w_flush;

    // Next state and pair-emission decision. A real byte arriving on the
    // cycle the idle timer expires takes priority over the pad flush.
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_EVEN: begin
                if (valid_in) begin
                    w_state_next = S_ODD;
                end
            end
            S_ODD: begin
                if (valid_in) begin
                    w_emit       = 1'b1;
                    w_state_next = S_EVEN;
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_emit       = 1'b1;
                    w_flush      = 1'b1;
                    w_state_next = S_EVEN;
                end
            end
            default: begin
                w_state_next = S_EVEN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_EVEN;
            r_hold       <= '0;
            r_idle_cnt   <= '0;
            r_data0      <= '0;
            r_data1      <= '0;
            r_valid      <= 1'b0;
            r_pad        <= 1'b0;
            r_pair_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_emit;
            r_pad   <= w_flush;

            if (r_state == S_EVEN && valid_in) begin
                r_hold     <= data_in;
                r_idle_cnt <= '0;
            end else if (r_state == S_ODD && !valid_in && !w_emit) begin
                r_idle_cnt <= r_idle_cnt + 8'd1;
            end

            // Lane data only moves when a pair is emitted, so it holds
            // its last value while the valids are low.
            if (w_emit) begin
                r_data0      <= r_hold;
                r_data1      <= w_flush ? PAD_BYTE : data_in;
                r_pair_count <= r_pair_count + 1'b1;
            end
        end
    end

    assign data_out0  = r_data0;
    assign data_out1  = r_data1;
    assign valid0     = r_valid;
    assign valid1     = r_valid;
    assign pad_out    = r_pad;
    assign pair_count = r_pair_count;

endmodule

// File: tb/tb_demux_1x2_8bits.sv
// tb/tb_demux_1x2_8bits.sv - self-checking bench for demux_1x2_8bits
module tb_demux_1x2_8bits;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        valid_in = 1'b0;
    logic [7:0]  data_out0, data_out1;
    logic        valid0, valid1, pad_out;
    logic [15:0] pair_count;

    // Second instance with a narrow counter so the wrap is reachable quickly.
    logic [7:0]  w_data_out0, w_data_out1;
    logic        w_valid0, w_valid1, w_pad_out;
    logic [7:0]  w_pair_count;

    always #5 clk = ~clk;

    demux_1x2_8bits dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out0(data_out0), .data_out1(data_out1),
        .valid0(valid0), .valid1(valid1), .pad_out(pad_out),
        .pair_count(pair_count)
    );

    demux_1x2_8bits #(.CNT_WIDTH(8)) dut_w (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out0(w_data_out0), .data_out1(w_data_out1),
        .valid0(w_valid0), .valid1(w_valid1), .pad_out(w_pad_out),
        .pair_count(w_pair_count)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       ev;
        logic [7:0] e0;
        logic [7:0] e1;
        logic       ep;
    } vec_t;

    typedef struct {
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        pad;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rst_q = 1'b0;
    logic        mon_en = 1'b0;
    logic [15:0] exp_cnt = 16'h0000;
    logic [7:0]  last0 = 8'h00;
    logic [7:0]  last1 = 8'h00;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic ev, input logic [7:0] e0,
                                input logic [7:0] e1, input logic ep);
        vec_t x;
        x.rst = r; x.v = v; x.d = d; x.ev = ev; x.e0 = e0; x.e1 = e1; x.ep = ep;
        return x;
    endfunction

    function automatic vec_t idle();
        return mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    endfunction

    function automatic vec_t byte_in(input logic [7:0] d);
        return mk(1'b0, 1'b1, d, 1'b0, 8'h00, 8'h00, 1'b0);
    endfunction

    // Drive one cycle of stimulus; a pair expected after this edge is pushed now.
    task automatic drive(input vec_t x);
        exp_t e;
        reset    = x.rst;
        valid_in = x.v;
        data_in  = x.d;
        if (x.rst) exp_cnt = 16'h0000;
        if (x.ev) begin
            exp_cnt = exp_cnt + 16'h0001;
            e.d0  = x.e0;
            e.d1  = x.e1;
            e.pad = x.ep;
            e.cnt = exp_cnt;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
    endtask

    // Output monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (valid1 !== valid0) begin
                errors++;
                $display("FAIL lane_valid_align: valid0=%b valid1=%b, required equal", valid0, valid1);
            end
            if (rst_q) begin
                checks++;
                if (data_out0 !== 8'h00 || data_out1 !== 8'h00 || valid0 !== 1'b0 ||
                    pad_out !== 1'b0 || pair_count !== 16'h0000) begin
                    errors++;
                    $display("FAIL reset_state: d0=%h d1=%h v0=%b pad=%b cnt=%h, required all zero",
                             data_out0, data_out1, valid0, pad_out, pair_count);
                end
                last0 = 8'h00;
                last1 = 8'h00;
            end else if (valid0 === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pair: cyc=%0d got (%h,%h) pad=%b, required no pair",
                             cyc, data_out0, data_out1, pad_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (data_out0 !== e.d0 || data_out1 !== e.d1 || pad_out !== e.pad ||
                        pair_count !== e.cnt || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL pair: got (%h,%h) pad=%b cnt=%0d cyc=%0d, required (%h,%h) pad=%b cnt=%0d cyc=%0d",
                                 data_out0, data_out1, pad_out, pair_count, cyc,
                                 e.d0, e.d1, e.pad, e.cnt, e.cyc);
                    end
                end
                last0 = data_out0;
                last1 = data_out1;
            end else begin
                checks++;
                if (pad_out !== 1'b0 || data_out0 !== last0 || data_out1 !== last1) begin
                    errors++;
                    $display("FAIL idle_hold: pad=%b d0=%h d1=%h, required pad=0 d0=%h d1=%h",
                             pad_out, data_out0, data_out1, last0, last1);
                end
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    errors++;
                    $display("FAIL missing_pair: cyc=%0d no pair, required (%h,%h) at cyc %0d",
                             cyc, sb[0].d0, sb[0].d1, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset held for 2 cycles with traffic present.
        vecs.push_back(mk(1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b0));
        // Continuous stream 01..06.
        vecs.push_back(byte_in(8'h01));
        vecs.push_back(mk(1'b0, 1'b1, 8'h02, 1'b1, 8'h01, 8'h02, 1'b0));
        vecs.push_back(byte_in(8'h03));
        vecs.push_back(mk(1'b0, 1'b1, 8'h04, 1'b1, 8'h03, 8'h04, 1'b0));
        vecs.push_back(byte_in(8'h05));
        vecs.push_back(mk(1'b0, 1'b1, 8'h06, 1'b1, 8'h05, 8'h06, 1'b0));
        vecs.push_back(idle());
        // Gapped pair: 3 empty cycles, no pad.
        vecs.push_back(byte_in(8'h10));
        vecs.push_back(idle()); vecs.push_back(idle()); vecs.push_back(idle());
        vecs.push_back(mk(1'b0, 1'b1, 8'h11, 1'b1, 8'h10, 8'h11, 1'b0));
        vecs.push_back(idle());
        // Orphan flush 4 cycles after acceptance, then 21 goes to lane 0.
        vecs.push_back(byte_in(8'h20));
        vecs.push_back(idle()); vecs.push_back(idle()); vecs.push_back(idle());
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 8'hF7, 1'b1));
        vecs.push_back(byte_in(8'h21));
        vecs.push_back(mk(1'b0, 1'b1, 8'h22, 1'b1, 8'h21, 8'h22, 1'b0));
        // Race: partner arrives when idle_cnt==3; no extra pad afterwards.
        vecs.push_back(byte_in(8'h30));
        vecs.push_back(idle()); vecs.push_back(idle()); vecs.push_back(idle());
        vecs.push_back(mk(1'b0, 1'b1, 8'h31, 1'b1, 8'h30, 8'h31, 1'b0));
        for (int i = 0; i < 6; i++) vecs.push_back(idle());
        // Two flushes back to back.
        vecs.push_back(byte_in(8'h60));
        vecs.push_back(idle()); vecs.push_back(idle()); vecs.push_back(idle());
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h60, 8'hF7, 1'b1));
        vecs.push_back(byte_in(8'h61));
        vecs.push_back(idle()); vecs.push_back(idle()); vecs.push_back(idle());
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h61, 8'hF7, 1'b1));
        vecs.push_back(idle());
        // Reset mid-pair: 40 discarded, no flush, 41 is lane 0.
        vecs.push_back(byte_in(8'h40));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
        for (int i = 0; i < 5; i++) vecs.push_back(idle());
        vecs.push_back(byte_in(8'h41));
        vecs.push_back(mk(1'b0, 1'b1, 8'h42, 1'b1, 8'h41, 8'h42, 1'b0));
        for (int i = 0; i < 6; i++) vecs.push_back(idle());

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #2;
            mon_en = 1'b1;
            drive(vecs[i]);
        end

        // Counter wrap: 256 back-to-back pairs into the narrow-counter instance.
        @(posedge clk); #2;
        drive(mk(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
        for (int k = 0; k <= 512; k++) begin
            @(posedge clk);
            #2;
            if (k >= 2 && (k % 2) == 0 && (k / 2 == 255 || k / 2 == 256)) begin
                checks++;
                if (w_pair_count !== 8'(k / 2) || w_valid0 !== 1'b1) begin
                    errors++;
                    $display("FAIL count_wrap: pair %0d got cnt=%0d v=%b, required cnt=%0d v=1",
                             k / 2, w_pair_count, w_valid0, 8'(k / 2));
                end
            end
            if (k < 512) begin
                if (k % 2 == 1)
                    drive(mk(1'b0, 1'b1, 8'(k), 1'b1, 8'(k - 1), 8'(k), 1'b0));
                else
                    drive(byte_in(8'(k)));
            end else begin
                drive(idle());
            end
        end

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            drive(idle());
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pairs outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
